// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: sequences core reset,
// bounds each run (limit / halt-PC / PC-stall / abort), repeats runs and
// emits a one-cycle-delayed PC trace.
module mips_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned RUN_CYCLES   = 100,
  parameter int unsigned NUM_RUNS     = 2,
  parameter int unsigned STALL_CYCLES = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      pc_in,
  input  logic             halt_pc_en,
  input  logic [31:0]      halt_pc,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic [2:0]       status,
  output logic [CNT_W-1:0] cycle_count,
  output logic [7:0]       run_idx,
  output logic             trace_valid,
  output logic [31:0]      trace_pc
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned IDX_W = 8;
  // Counters only need to reach their terminal value (N-1)
  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam int unsigned STL_W = $clog2(STALL_CYCLES);

  localparam logic [2:0] ST_NONE  = 3'd0;
  localparam logic [2:0] ST_LIMIT = 3'd1;
  localparam logic [2:0] ST_HALT  = 3'd2;
  localparam logic [2:0] ST_STALL = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [STL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [2:0]         status_q, status_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   run_idx_q, run_idx_d;
  logic               core_rst_q, core_rst_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               trace_valid_q, trace_valid_d;
  logic [PC_W-1:0]    trace_pc_q, trace_pc_d;

  logic pc_same;
  logic hit_abort, hit_halt, hit_stall, hit_limit, hit_any;

  // Termination conditions; trace_pc_q doubles as the previous-cycle PC
  assign pc_same   = (run_cnt_q != '0) && (pc_in == trace_pc_q);
  assign hit_abort = abort;
  assign hit_halt  = halt_pc_en && (pc_in == halt_pc);
  assign hit_stall = pc_same && (stall_cnt_q == STL_W'(STALL_CYCLES - 2));
  assign hit_limit = (run_cnt_q == RUN_W'(RUN_CYCLES - 1));
  assign hit_any   = hit_abort || hit_halt || hit_stall || hit_limit;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    run_cnt_d     = run_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    status_d      = status_q;
    cnt_d         = cnt_q;
    run_idx_d     = run_idx_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (abort) begin
            // abort beats start; only a fresh IDLE reports it
            if (state_q == S_IDLE) begin
              state_d  = S_DONE;
              status_d = ST_ABORT;
            end
          end else begin
            state_d   = S_RST;
            status_d  = ST_NONE;
            cnt_d     = '0;
            run_idx_d = '0;
            rst_cnt_d = '0;
          end
        end
      end
      S_RST: begin
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
          state_d     = S_RUN;
          cnt_d       = '0;
          run_cnt_d   = '0;
          stall_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      S_RUN: begin
        cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        run_cnt_d   = hit_limit ? run_cnt_q : run_cnt_q + RUN_W'(1);
        stall_cnt_d = pc_same ? stall_cnt_q + STL_W'(1) : '0;
        if (hit_any) begin
          if (hit_abort)      status_d = ST_ABORT;
          else if (hit_halt)  status_d = ST_HALT;
          else if (hit_stall) status_d = ST_STALL;
          else                status_d = ST_LIMIT;
          rst_cnt_d = '0;
          if (hit_abort || (run_idx_q == IDX_W'(NUM_RUNS - 1))) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_RST;
            run_idx_d = run_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    core_rst_d    = (state_d != S_RUN);
    running_d     = (state_d == S_RUN);
    done_d        = (state_d == S_DONE);
    trace_valid_d = running_q;
    trace_pc_d    = pc_in;
  end

  // State and output registers
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      run_cnt_q     <= '0;
      stall_cnt_q   <= '0;
      status_q      <= ST_NONE;
      cnt_q         <= '0;
      run_idx_q     <= '0;
      core_rst_q    <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      run_cnt_q     <= run_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      status_q      <= status_d;
      cnt_q         <= cnt_d;
      run_idx_q     <= run_idx_d;
      core_rst_q    <= core_rst_d;
      running_q     <= running_d;
      done_q        <= done_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
    end
  end

  assign core_rst    = core_rst_q;
  assign running     = running_q;
  assign done        = done_q;
  assign status      = status_q;
  assign cycle_count = cnt_q;
  assign run_idx     = run_idx_q;
  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: a timeline model of each reset/run
// sequence pushes expected post-edge outputs; a monitor pops and compares.
// DUT a: default bench parameters. DUT b: 3-bit cycle counter, 10-cycle runs.
module tb_mips_run_ctrl;

  typedef struct packed {
    logic        cr;
    logic        run;
    logic        dn;
    logic [2:0]  st;
    logic [31:0] cc;
    logic [7:0]  idx;
    logic        tv;
    logic [31:0] tpc;
  } exp_t;

  localparam int RST_CYC = 2;
  localparam int STALL_N = 4;
  localparam int NRUNS   = 2;
  localparam int M_LIMIT = 0, M_HALT = 1, M_STALL = 2, M_STALLHALT = 3, M_RAND = 4;

  logic clk = 1'b0;
  logic R   = 1'b0;

  logic        a_start = 0, a_abort = 0, a_hen = 0;
  logic [31:0] a_pc = 0, a_hpc = 0;
  logic        a_core_rst, a_running, a_done, a_tv;
  logic [2:0]  a_status;
  logic [31:0] a_cc, a_tpc;
  logic [7:0]  a_idx;

  logic        b_start = 0, b_abort = 0, b_hen = 0;
  logic [31:0] b_pc = 0, b_hpc = 0;
  logic        b_core_rst, b_running, b_done, b_tv;
  logic [2:0]  b_status;
  logic [2:0]  b_cc;
  logic [31:0] b_tpc;
  logic [7:0]  b_idx;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic [2:0]  m_status [2];
  logic [31:0] m_cc     [2];
  logic [7:0]  m_idx    [2];
  logic        m_done   [2];
  logic        m_run    [2];

  always #5 clk = ~clk;

  mips_run_ctrl #(.RESET_CYCLES(2), .RUN_CYCLES(8), .NUM_RUNS(2), .STALL_CYCLES(4), .CNT_W(32)) u_a (
    .clk(clk), .R(R), .start(a_start), .abort(a_abort), .pc_in(a_pc),
    .halt_pc_en(a_hen), .halt_pc(a_hpc), .core_rst(a_core_rst), .running(a_running),
    .done(a_done), .status(a_status), .cycle_count(a_cc), .run_idx(a_idx),
    .trace_valid(a_tv), .trace_pc(a_tpc));

  mips_run_ctrl #(.RESET_CYCLES(2), .RUN_CYCLES(10), .NUM_RUNS(2), .STALL_CYCLES(4), .CNT_W(3)) u_b (
    .clk(clk), .R(R), .start(b_start), .abort(b_abort), .pc_in(b_pc),
    .halt_pc_en(b_hen), .halt_pc(b_hpc), .core_rst(b_core_rst), .running(b_running),
    .done(b_done), .status(b_status), .cycle_count(b_cc), .run_idx(b_idx),
    .trace_valid(b_tv), .trace_pc(b_tpc));

  function automatic int runc(input int d);
    return (d == 0) ? 8 : 10;
  endfunction

  function automatic int unsigned cmax(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : 7;
  endfunction

  function automatic exp_t mk(input logic cr, input logic run, input logic dn,
                              input logic [2:0] st, input logic [31:0] cc, input logic [7:0] idx);
    exp_t e;
    e.cr = cr; e.run = run; e.dn = dn; e.st = st; e.cc = cc; e.idx = idx;
    e.tv = 1'b0; e.tpc = '0;
    return e;
  endfunction

  function automatic exp_t obs(input int d);
    exp_t e;
    if (d == 0) begin
      e = '{cr: a_core_rst, run: a_running, dn: a_done, st: a_status, cc: a_cc,
            idx: a_idx, tv: a_tv, tpc: a_tpc};
    end else begin
      e = '{cr: b_core_rst, run: b_running, dn: b_done, st: b_status, cc: {29'd0, b_cc},
            idx: b_idx, tv: b_tv, tpc: b_tpc};
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_pc();
    return 32'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom & 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_status[d] = '0; m_cc[d] = '0; m_idx[d] = '0; m_done[d] = 1'b0; m_run[d] = 1'b0;
    end
  endtask

  // Apply one cycle of inputs, then queue what the outputs must be after the edge
  task automatic step(input int d, input logic st, input logic ab, input logic [31:0] pc,
                      input logic hen, input logic [31:0] hpc, input exp_t e);
    if (d == 0) begin
      a_start = st; a_abort = ab; a_pc = pc; a_hen = hen; a_hpc = hpc;
    end else begin
      b_start = st; b_abort = ab; b_pc = pc; b_hen = hen; b_hpc = hpc;
    end
    @(posedge clk);
    e.tv  = m_run[d];
    e.tpc = pc;
    m_run[d] = e.run;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    #1;
    if (d == 0) begin a_start = 0; a_abort = 0; end else begin b_start = 0; b_abort = 0; end
  endtask

  // start+abort together: reported from IDLE, ignored in DONE
  task automatic start_abort(input int d);
    if (!m_done[d]) begin
      m_status[d] = 3'd4;
      m_done[d]   = 1'b1;
    end
    step(d, 1, 1, rand_pc(), 0, 0, mk(1, 0, 1, m_status[d], m_cc[d], m_idx[d]));
  endtask

  // One full start sequence; each run's end is found by scanning its PC stream
  task automatic run_seq(input int d, input int mode, input int idle_n,
                         input int ab_run, input int ab_cyc, input int cut);
    logic [31:0] pc, prev, hpc, base;
    logic        hen, ab;
    int          streak;
    logic [2:0]  cause;
    int unsigned cc;
    repeat (idle_n) step(d, 0, 0, rand_pc(), 0, 0, mk(1, 0, m_done[d], m_status[d], m_cc[d], m_idx[d]));
    step(d, 1, 0, rand_pc(), 0, 0, mk(1, 0, 0, 0, 0, 0));
    m_done[d] = 0; m_status[d] = 0; m_cc[d] = 0; m_idx[d] = 0;
    for (int r = 0; r < NRUNS; r++) begin
      for (int j = 1; j <= RST_CYC; j++) begin
        if (r == ab_run && j == ab_cyc) begin
          m_status[d] = 3'd4; m_done[d] = 1'b1;
          step(d, rbit(), 1, rand_pc(), 0, 0, mk(1, 0, 1, 3'd4, m_cc[d], m_idx[d]));
          return;
        end else if (j < RST_CYC) begin
          step(d, rbit(), 0, rand_pc(), 0, 0, mk(1, 0, 0, m_status[d], m_cc[d], m_idx[d]));
        end else begin
          m_cc[d] = 0;
          step(d, rbit(), 0, rand_pc(), 0, 0, mk(0, 1, 0, m_status[d], 0, m_idx[d]));
        end
      end
      base   = 32'($urandom_range(0, 255)) << 2;
      hpc    = 32'($urandom_range(0, 7)) << 2;
      prev   = 32'($urandom_range(0, 7)) << 2;
      streak = 0;
      for (int i = 1; i <= runc(d); i++) begin
        hen = 1'b0;
        ab  = 1'b0;
        case (mode)
          M_LIMIT: pc = base + 32'(4 * (i - 1));
          M_HALT: begin pc = 32'(4 * (i - 1)); hpc = 32'h0000_000C; hen = 1'b1; end
          M_STALL: pc = (i == 1) ? 32'd0 : 32'd4;
          M_STALLHALT: begin pc = (i == 1) ? 32'd0 : 32'd4; hpc = 32'd4; hen = (i == 5); end
          default: begin
            case ($urandom_range(0, 3))
              0, 1:    pc = prev;
              2:       pc = prev + 32'd4;
              default: pc = 32'($urandom_range(0, 7)) << 2;
            endcase
            hen = ($urandom_range(0, 2) == 0);
            ab  = ($urandom_range(0, 19) == 0);
          end
        endcase
        streak = (i > 1 && pc == prev) ? streak + 1 : 1;
        prev   = pc;
        if (ab)                       cause = 3'd4;
        else if (hen && pc == hpc)    cause = 3'd2;
        else if (streak >= STALL_N)   cause = 3'd3;
        else if (i == runc(d))        cause = 3'd1;
        else                          cause = 3'd0;
        cc = (32'(i) > cmax(d)) ? cmax(d) : 32'(i);
        if (cause == 3'd0) begin
          step(d, rbit(), 0, pc, hen, hpc, mk(0, 1, 0, m_status[d], cc, m_idx[d]));
          if (r == 0 && i == cut) return;
        end else begin
          m_status[d] = cause;
          m_cc[d]     = cc;
          if (cause == 3'd4 || r == NRUNS - 1) begin
            m_done[d] = 1'b1;
            step(d, rbit(), ab, pc, hen, hpc, mk(1, 0, 1, cause, cc, m_idx[d]));
            return;
          end
          m_idx[d] = 8'(r + 1);
          step(d, rbit(), ab, pc, hen, hpc, mk(1, 0, 0, cause, cc, m_idx[d]));
          break;
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_core_rst"}, 32'(a_core_rst), 32'd1);
    chk({tag, "_running"},  32'(a_running),  32'd0);
    chk({tag, "_done"},     32'(a_done),     32'd0);
    chk({tag, "_status"},   32'(a_status),   32'd0);
    chk({tag, "_cc"},       a_cc,            32'd0);
    chk({tag, "_run_idx"},  32'(a_idx),      32'd0);
    chk({tag, "_tvalid"},   32'(a_tv),       32'd0);
    chk({tag, "_tpc"},      a_tpc,           32'd0);
    chk({tag, "_b_cc"},     32'(b_cc),       32'd0);
  endtask

  // Monitor: one queued expectation per DUT per clock
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if ((d == 0 && q0.size() > 0) || (d == 1 && q1.size() > 0)) begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          a = obs(d);
          n_tests++;
          if (a !== e) begin
            n_fail++;
            $display("FAIL dut%0d t=%0t got cr=%b run=%b dn=%b st=%0d cc=%0d idx=%0d tv=%b tpc=%h want cr=%b run=%b dn=%b st=%0d cc=%0d idx=%0d tv=%b tpc=%h",
                     d, $time, a.cr, a.run, a.dn, a.st, a.cc, a.idx, a.tv, a.tpc,
                     e.cr, e.run, e.dn, e.st, e.cc, e.idx, e.tv, e.tpc);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    @(negedge clk);
    R = 1'b1;
    @(posedge clk);
    #1;

    // start+abort from IDLE, then again from DONE
    start_abort(0);
    start_abort(0);
    // abort in the first reset window
    run_seq(0, M_LIMIT, 2, 0, 2, 0);
    // two full LIMIT runs
    run_seq(0, M_LIMIT, 3, -1, 0, 0);
    run_seq(0, M_HALT, 1, -1, 0, 0);
    run_seq(0, M_STALL, 1, -1, 0, 0);
    run_seq(0, M_STALLHALT, 1, -1, 0, 0);
    // abort during the second run's reset window
    run_seq(0, M_LIMIT, 1, 1, 1, 0);

    // asynchronous reset in the middle of a run
    run_seq(0, M_LIMIT, 1, -1, 0, 3);
    @(negedge clk);
    #2;
    a_start = 0; a_abort = 0; b_start = 0; b_abort = 0;
    R = 1'b0;
    #1;
    check_reset_values("midrun");
    @(posedge clk);
    @(negedge clk);
    R = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    for (int k = 0; k < 40; k++) begin
      run_seq(0, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : M_RAND,
              $urandom_range(0, 3), ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1) : -1,
              $urandom_range(1, 2), 0);
    end

    // saturating 3-bit counter on 10-cycle runs
    run_seq(1, M_LIMIT, 2, -1, 0, 0);
    run_seq(1, M_HALT, 1, -1, 0, 0);
    for (int k = 0; k < 15; k++) begin
      run_seq(1, M_RAND, $urandom_range(0, 2), -1, 0, 0);
    end

    repeat (2) @(negedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
